// File: rtl/alu_bcd_seq.sv
// rtl/alu_bcd_seq.sv - sequential ALU with start/done handshake and double-dabble BCD conversion
//
// Ports:
//   clk    : system clock, all state on the rising edge
//   rst    : synchronous, active-high reset
//   start  : operation request, sampled only while idle
//   a, b   : unsigned operands (WIDTH bits), captured with start
//   func   : operation select (add/sub/mul/div/concat/mod), captured with start
//   busy   : high whenever the sequencer is not idle
//   done   : one-cycle pulse; result/bcd/err valid from this cycle
//   result : binary result (2*WIDTH bits), held until the next done
//   bcd    : packed BCD of result, digit 0 in [3:0], held until the next done
//   err    : error flag of the last operation, held until the next done
module alu_bcd_seq #(
  parameter int WIDTH  = 6,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      a,
  input  logic [WIDTH-1:0]      b,
  input  logic [2:0]            func,
  output logic                  busy,
  output logic                  done,
  output logic [2*WIDTH-1:0]    result,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  err
);

  localparam int RW = 2 * WIDTH;
  localparam int BW = 4 * DIGITS;
  // ceil(RW * log10(2)) in integer arithmetic
  localparam int MIN_DIGITS = (RW * 30103 + 99999) / 100000;
  localparam int CW = $clog2(RW + 1);
  localparam logic [CW-1:0] CALC_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CONV_LAST = CW'(RW - 1);

  localparam logic [2:0] F_ADD = 3'b000;
  localparam logic [2:0] F_SUB = 3'b001;
  localparam logic [2:0] F_MUL = 3'b010;
  localparam logic [2:0] F_DIV = 3'b011;
  localparam logic [2:0] F_CAT = 3'b100;
  localparam logic [2:0] F_MOD = 3'b101;

  generate
    if (DIGITS < MIN_DIGITS) begin : g_digits_check
      $error("alu_bcd_seq: DIGITS too small to hold 2*WIDTH-bit result");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_CONV, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, b_q;
  logic [2:0]        func_q;
  logic [CW-1:0]     cnt_q;
  logic [RW-1:0]     acc_q, acc_n;      // mul: partial product; div/mod: partial remainder
  logic [WIDTH-1:0]  q_q, q_n;          // mul: multiplier bits; div/mod: dividend in, quotient out
  logic [WIDTH:0]    shifted, rem;
  logic              q_bit;
  logic [RW-1:0]     calc_res;
  logic              calc_err;
  logic [RW-1:0]     res_q;
  logic              err_q;
  logic [RW-1:0]     bin_q;
  logic [BW-1:0]     dig_q, dig_n;
  logic [3:0]        nib;
  logic              carry;
  logic              long_op, calc_last, conv_last;

  assign long_op   = (func_q == F_MUL) || (func_q == F_DIV) || (func_q == F_MOD);
  assign calc_last = long_op ? (cnt_q == CALC_LAST) : 1'b1;
  assign conv_last = (cnt_q == CONV_LAST);

  // One iteration of MSB-first shift-add multiply or restoring divide.
  always_comb begin
    acc_n   = acc_q;
    q_n     = q_q;
    rem     = '0;
    q_bit   = 1'b0;
    shifted = {acc_q[WIDTH-1:0], q_q[WIDTH-1]};
    if (func_q == F_MUL) begin
      acc_n = {acc_q[RW-2:0], 1'b0} + (q_q[WIDTH-1] ? {{WIDTH{1'b0}}, a_q} : {RW{1'b0}});
      q_n   = {q_q[WIDTH-2:0], 1'b0};
    end else begin
      if (shifted >= {1'b0, b_q}) begin
        rem   = shifted - {1'b0, b_q};
        q_bit = 1'b1;
      end else begin
        rem   = shifted;
      end
      acc_n = {{(RW-WIDTH-1){1'b0}}, rem};
      q_n   = {q_q[WIDTH-2:0], q_bit};
    end
  end

  // Final value, taken on the last CALC cycle (uses the last iteration's outputs).
  always_comb begin
    calc_res = '0;
    calc_err = 1'b0;
    case (func_q)
      F_ADD: calc_res = {{WIDTH{1'b0}}, a_q} + {{WIDTH{1'b0}}, b_q};
      F_SUB: if (a_q < b_q) calc_err = 1'b1;
             else calc_res = {{WIDTH{1'b0}}, a_q - b_q};
      F_MUL: calc_res = acc_n;
      F_DIV: if (b_q == '0) calc_err = 1'b1;
             else calc_res = {{WIDTH{1'b0}}, q_n};
      F_CAT: calc_res = {a_q, b_q};
      F_MOD: if (b_q == '0) calc_err = 1'b1;
             else calc_res = {{WIDTH{1'b0}}, acc_n[WIDTH-1:0]};
      default: calc_err = 1'b1;
    endcase
  end

  // Double dabble step: add 3 to every digit >= 5, then shift one binary bit in.
  // The carry out of the top digit is always zero given the DIGITS check.
  always_comb begin
    dig_n = '0;
    nib   = '0;
    carry = bin_q[RW-1];
    for (int i = 0; i < DIGITS; i++) begin
      nib = dig_q[4*i +: 4];
      if (nib >= 4'd5) nib = nib + 4'd3;
      dig_n[4*i +: 4] = {nib[2:0], carry};
      carry = nib[3];
    end
  end

  always_comb begin
    state_d = state_q;
    busy    = (state_q != S_IDLE);
    done    = (state_q == S_DONE);
    case (state_q)
      S_IDLE: if (start) state_d = S_CALC;
      S_CALC: if (calc_last) state_d = S_CONV;
      S_CONV: if (conv_last) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      func_q <= '0;
      cnt_q  <= '0;
      acc_q  <= '0;
      q_q    <= '0;
      res_q  <= '0;
      err_q  <= 1'b0;
      bin_q  <= '0;
      dig_q  <= '0;
      result <= '0;
      bcd    <= '0;
      err    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (start) begin
          a_q    <= a;
          b_q    <= b;
          func_q <= func;
          cnt_q  <= '0;
          acc_q  <= '0;
          q_q    <= (func == F_MUL) ? b : a;
        end
        S_CALC: begin
          acc_q <= acc_n;
          q_q   <= q_n;
          if (calc_last) begin
            cnt_q <= '0;
            res_q <= calc_res;
            err_q <= calc_err;
            bin_q <= calc_res;
            dig_q <= '0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_CONV: begin
          bin_q <= {bin_q[RW-2:0], 1'b0};
          dig_q <= dig_n;
          if (conv_last) begin
            cnt_q  <= '0;
            result <= res_q;
            bcd    <= dig_n;
            err    <= err_q;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_bcd_seq.sv
// tb/tb_alu_bcd_seq.sv - directed self-checking bench for alu_bcd_seq
module tb_alu_bcd_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [5:0]  a = '0;
  logic [5:0]  b = '0;
  logic [2:0]  func = '0;
  logic        busy, done, err;
  logic [11:0] result;
  logic [15:0] bcd;

  int n_checks = 0;
  int n_fail = 0;

  alu_bcd_seq #(.WIDTH(6), .DIGITS(4)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .func(func),
    .busy(busy), .done(done), .result(result), .bcd(bcd), .err(err)
  );

  always #5 clk = ~clk;

  task automatic wait_done(output int lat);
    lat = 0;
    while (done !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_op(input logic [2:0] f, input logic [5:0] x, input logic [5:0] y, output int lat);
    @(negedge clk);
    func = f; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %0b want 0", done); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %0b want 0", err); end
    n_checks++; if (result !== 12'd0) begin n_fail++; $display("FAIL reset_result got %0d want 0", result); end
    n_checks++; if (bcd !== 16'h0000) begin n_fail++; $display("FAIL reset_bcd got %h want 0000", bcd); end
    rst = 1'b0;
  endtask

  task automatic test_add();
    int lat;
    run_op(3'b000, 6'd63, 6'd63, lat);
    n_checks++; if (lat != 13) begin n_fail++; $display("FAIL add_latency got %0d want 13", lat); end
    n_checks++; if (result !== 12'd126) begin n_fail++; $display("FAIL add_result got %0d want 126", result); end
    n_checks++; if (bcd !== 16'h0126) begin n_fail++; $display("FAIL add_bcd got %h want 0126", bcd); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL add_err got %0b want 0", err); end
    @(negedge clk);
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL add_done_pulse got %0b want 0", done); end
    n_checks++; if (result !== 12'd126) begin n_fail++; $display("FAIL add_result_hold got %0d want 126", result); end
  endtask

  task automatic test_back_to_back();
    int lat;
    @(negedge clk);
    func = 3'b010; a = 6'd63; b = 6'd63; start = 1'b1;
    @(negedge clk);
    wait_done(lat);
    n_checks++; if (lat != 18) begin n_fail++; $display("FAIL mul_latency got %0d want 18", lat); end
    n_checks++; if (result !== 12'd3969) begin n_fail++; $display("FAIL mul_result got %0d want 3969", result); end
    n_checks++; if (bcd !== 16'h3969) begin n_fail++; $display("FAIL mul_bcd got %h want 3969", bcd); end
    a = 6'd10; b = 6'd12;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_busy got %0b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_done got %0b want 0", done); end
    wait_done(lat);
    start = 1'b0;
    n_checks++; if (lat != 19) begin n_fail++; $display("FAIL b2b_latency got %0d want 19", lat); end
    n_checks++; if (result !== 12'd120) begin n_fail++; $display("FAIL b2b_result got %0d want 120", result); end
    n_checks++; if (bcd !== 16'h0120) begin n_fail++; $display("FAIL b2b_bcd got %h want 0120", bcd); end
  endtask

  task automatic test_div_mod();
    int lat;
    run_op(3'b011, 6'd50, 6'd7, lat);
    n_checks++; if (lat != 18) begin n_fail++; $display("FAIL div_latency got %0d want 18", lat); end
    n_checks++; if (result !== 12'd7) begin n_fail++; $display("FAIL div_result got %0d want 7", result); end
    n_checks++; if (bcd !== 16'h0007) begin n_fail++; $display("FAIL div_bcd got %h want 0007", bcd); end
    run_op(3'b101, 6'd50, 6'd7, lat);
    n_checks++; if (result !== 12'd1) begin n_fail++; $display("FAIL mod_result got %0d want 1", result); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL mod_err got %0b want 0", err); end
    run_op(3'b011, 6'd50, 6'd0, lat);
    n_checks++; if (lat != 18) begin n_fail++; $display("FAIL div0_latency got %0d want 18", lat); end
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL div0_err got %0b want 1", err); end
    n_checks++; if (result !== 12'd0) begin n_fail++; $display("FAIL div0_result got %0d want 0", result); end
    run_op(3'b101, 6'd33, 6'd0, lat);
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL mod0_err got %0b want 1", err); end
    n_checks++; if (result !== 12'd0) begin n_fail++; $display("FAIL mod0_result got %0d want 0", result); end
    n_checks++; if (bcd !== 16'h0000) begin n_fail++; $display("FAIL mod0_bcd got %h want 0000", bcd); end
  endtask

  task automatic test_sub_illegal();
    int lat;
    run_op(3'b001, 6'd5, 6'd9, lat);
    n_checks++; if (lat != 13) begin n_fail++; $display("FAIL sub_neg_latency got %0d want 13", lat); end
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL sub_neg_err got %0b want 1", err); end
    n_checks++; if (result !== 12'd0) begin n_fail++; $display("FAIL sub_neg_result got %0d want 0", result); end
    run_op(3'b001, 6'd9, 6'd5, lat);
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL sub_err got %0b want 0", err); end
    n_checks++; if (result !== 12'd4) begin n_fail++; $display("FAIL sub_result got %0d want 4", result); end
    n_checks++; if (bcd !== 16'h0004) begin n_fail++; $display("FAIL sub_bcd got %h want 0004", bcd); end
    run_op(3'b111, 6'd20, 6'd3, lat);
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL illegal_err got %0b want 1", err); end
    n_checks++; if (result !== 12'd0) begin n_fail++; $display("FAIL illegal_result got %0d want 0", result); end
  endtask

  task automatic test_ignore_busy();
    int lat;
    @(negedge clk);
    func = 3'b010; a = 6'd7; b = 6'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0; func = 3'b000; a = 6'd63; b = 6'd63;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = 6'd1; b = 6'd2;
    wait_done(lat);
    n_checks++; if (lat + 2 != 18) begin n_fail++; $display("FAIL ignore_latency got %0d want 18", lat + 2); end
    n_checks++; if (result !== 12'd63) begin n_fail++; $display("FAIL ignore_result got %0d want 63", result); end
    n_checks++; if (bcd !== 16'h0063) begin n_fail++; $display("FAIL ignore_bcd got %h want 0063", bcd); end
    repeat (2) begin
      @(negedge clk);
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ignore_not_queued got busy=%0b want 0", busy); end
    end
  endtask

  task automatic test_reset_abort();
    bit seen;
    @(negedge clk);
    func = 3'b010; a = 6'd63; b = 6'd63; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %0b want 0", busy); end
    n_checks++; if (result !== 12'd0) begin n_fail++; $display("FAIL abort_result got %0d want 0", result); end
    n_checks++; if (bcd !== 16'h0000) begin n_fail++; $display("FAIL abort_bcd got %h want 0000", bcd); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL abort_err got %0b want 0", err); end
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
    end
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL abort_no_done got activity=%0b want 0", seen); end
  endtask

  task automatic test_concat();
    int lat;
    run_op(3'b100, 6'h2A, 6'h15, lat);
    n_checks++; if (lat != 13) begin n_fail++; $display("FAIL cat_latency got %0d want 13", lat); end
    n_checks++; if (result !== 12'hA95) begin n_fail++; $display("FAIL cat_result got %h want a95", result); end
    n_checks++; if (bcd !== 16'h2709) begin n_fail++; $display("FAIL cat_bcd got %h want 2709", bcd); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL cat_err got %0b want 0", err); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_div_mod();
    test_sub_illegal();
    test_ignore_busy();
    test_reset_abort();
    test_concat();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
